pulse_tx_refill_ctrl: RTL and testbench
=======================================

PULSE_TX_REFILL_CTRL -- requirements
Module: pulse_tx_refill_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 5, meaning the number of 32-bit symbol words in the transmitter data memory (ring size).
REQ-002 SHALL have port clk, input, 1, clock; reset rst_n, synchronous, active-low.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port enable, input, 1, level that arms the controller; low forces IDLE.
REQ-005 SHALL have port prime_thresh, input, 3, word count that starts transmission; 0 is treated as 1, values above DEPTH as DEPTH.
REQ-006 SHALL have port low_water, input, 3, refill-interrupt threshold on the outstanding word count.
REQ-007 SHALL have port flush, input, 1, level meaning no further words will be pushed.
REQ-008 SHALL have ports wr_valid (input, 1), wr_data (input, 32) and wr_ready (output, 1), the CPU-side word push handshake.
REQ-009 SHALL have port word_done, input, 1, one-cycle pulse from the transmitter when its program counter leaves a 16-symbol word.
REQ-010 SHALL have ports mem_we (output, 1), mem_waddr (output, 3) and mem_wdata (output, 32), the write port into transmitter data memory.
REQ-011 SHALL have port tx_run, output, 1, drives transmitter start (level); its rising edge starts a program.
REQ-012 SHALL have port count, output, 3, number of outstanding unconsumed words.
REQ-013 SHALL have ports irq_low (output, 1), irq_clr (input, 1), underrun (output, 1) and done (output, 1).

Function
REQ-014 SHALL implement states IDLE, PRIME, RUN, DRAIN, UNDERRUN and DONE.
REQ-015 SHALL, in any state, go to IDLE and clear wp, count, underrun, done and irq_low on the cycle after enable is sampled low.
REQ-016 SHALL move from IDLE to PRIME when enable is sampled high.
REQ-017 SHALL drive wr_ready = 1 only in PRIME or RUN with count < DEPTH; the handshake completes on a cycle with wr_valid && wr_ready.
REQ-018 SHALL, on handshake, register mem_we=1, mem_waddr=wp and mem_wdata=wr_data for exactly the next cycle, then advance wp modulo DEPTH (DEPTH-1 wraps to 0).
REQ-019 SHALL increment count on handshake and decrement it on word_done; when both occur in the same cycle, count is unchanged.
REQ-020 SHALL move from PRIME to RUN when count >= effective prime_thresh and mem_we is 0, so the last priming write is committed before tx_run rises.
REQ-021 SHALL ignore word_done in IDLE, PRIME, DONE and UNDERRUN.
REQ-022 SHALL drive tx_run = 1 exactly in RUN and DRAIN, registered.
REQ-023 SHALL move from RUN to DRAIN when flush is sampled high; DRAIN has wr_ready = 0.
REQ-024 SHALL move from DRAIN to DONE on a word_done that takes count to 0, and set done (sticky).
REQ-025 SHALL move from RUN to UNDERRUN on a word_done that takes count to 0 when flush is 0 and no handshake occurs in the same cycle, and set underrun (sticky).
REQ-026 SHALL ignore a word_done arriving at count 0 in RUN or DRAIN without wrapping count, and treat it as underrun in RUN or as done in DRAIN.
REQ-027 SHALL set irq_low when in RUN with count <= low_water; irq_clr clears it, and set takes priority over clear in the same cycle.
REQ-028 SHALL keep count within 0..DEPTH at all times.

Reset
REQ-029 SHALL, on rst_n low at a clock edge, set state IDLE, wp 0, count 0, wr_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, tx_run 0, irq_low 0, underrun 0 and done 0.
REQ-030 SHALL abort any pending write on reset asserted mid-operation, so mem_we is 0 on the following cycle.

Verification
REQ-031 Prime: prime_thresh=2, push A then B -> mem writes to addr 0 then 1, one cycle after each handshake; tx_run rises the cycle after mem_we for B drops; count=2.
REQ-032 Wrap/full: DEPTH=5, push 5 words -> wr_ready=0 at count=5; word_done -> count=4 and wr_ready=1; the next push writes addr 0.
REQ-033 Simultaneous: handshake and word_done in the same cycle at count=1 in RUN -> count stays 1, no underrun.
REQ-034 Underrun: RUN with count=1 and flush=0, word_done -> count=0, underrun=1, tx_run=0 next cycle, wr_ready=0 until enable toggles.
REQ-035 Drain: flush=1 with count=3, three word_done pulses -> done=1 and tx_run=0 after the third; irq_low set while count <= low_water=1, until irq_clr and state leaves RUN.
REQ-036 Reset mid-write: rst_n low on the cycle after a handshake -> mem_we=0, count=0, state IDLE.

Source files
------------

// File: rtl/pulse_tx_refill_ctrl.sv
// Refill controller for a pulse transmitter: primes a small ring of symbol words,
// runs the transmitter, tracks outstanding words and reports underrun / done / low-water.
module pulse_tx_refill_ctrl #(
  parameter int DEPTH = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  prime_thresh,
  input  logic [2:0]  low_water,
  input  logic        flush,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic        word_done,
  output logic        mem_we,
  output logic [2:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        tx_run,
  output logic [2:0]  count,
  output logic        irq_low,
  input  logic        irq_clr,
  output logic        underrun,
  output logic        done,
  output logic [2:0]  dbg_state
);

  // wr_valid/wr_ready: a word transfers on any cycle where both are high;
  // wr_ready never depends on wr_valid, and wr_data is only sampled on transfer.

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [2:0] LAST_C  = 3'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRIME    = 3'd1,
    S_RUN      = 3'd2,
    S_DRAIN    = 3'd3,
    S_UNDERRUN = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  wp_q, wp_d;
  logic [2:0]  count_q, count_d;
  logic        mem_we_q, mem_we_d;
  logic [2:0]  mem_waddr_q, mem_waddr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        tx_run_q, tx_run_d;
  logic        irq_low_q, irq_low_d;
  logic        underrun_q, underrun_d;
  logic        done_q, done_d;

  logic [2:0]  eff_thresh;
  logic        accepting;
  logic        hs;
  logic        wd_seen;
  logic        wd_dec;
  logic        drained;

  always_comb begin
    eff_thresh = prime_thresh;
    if (prime_thresh == 3'd0) begin
      eff_thresh = 3'd1;
    end else if (prime_thresh > DEPTH_C) begin
      eff_thresh = DEPTH_C;
    end
  end

  // Pushes are refused once enable drops so nothing is written after the abort.
  assign accepting = enable && ((state_q == S_PRIME) || (state_q == S_RUN));
  assign wr_ready  = accepting && (count_q < DEPTH_C);
  assign hs        = wr_valid && wr_ready;
  assign wd_seen   = word_done && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign wd_dec    = wd_seen && (count_q != 3'd0);

  always_comb begin
    count_d = count_q;
    if (hs && !wd_dec) begin
      count_d = count_q + 3'd1;
    end else if (!hs && wd_dec) begin
      count_d = count_q - 3'd1;
    end
  end

  // A consumed word that leaves nothing outstanding; a stray pulse at zero counts too.
  assign drained = wd_seen && (count_d == 3'd0);

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    irq_low_d   = irq_low_q;
    underrun_d  = underrun_q;
    done_d      = done_q;

    if (hs) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = wp_q;
      mem_wdata_d = wr_data;
      wp_d        = (wp_q == LAST_C) ? 3'd0 : (wp_q + 3'd1);
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = S_PRIME;
      end
      S_PRIME: begin
        if ((count_q >= eff_thresh) && !mem_we_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (drained) begin
          if (flush) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_UNDERRUN;
            underrun_d = 1'b1;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_UNDERRUN: state_d = S_UNDERRUN;
      S_DONE:     state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase

    if ((state_q == S_RUN) && (count_q <= low_water)) begin
      irq_low_d = 1'b1;
    end else if (irq_clr) begin
      irq_low_d = 1'b0;
    end

    if (!enable) begin
      state_d    = S_IDLE;
      wp_d       = 3'd0;
      irq_low_d  = 1'b0;
      underrun_d = 1'b0;
      done_d     = 1'b0;
    end

    tx_run_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wp_q        <= 3'd0;
      count_q     <= 3'd0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= 3'd0;
      mem_wdata_q <= 32'd0;
      tx_run_q    <= 1'b0;
      irq_low_q   <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      count_q     <= enable ? count_d : 3'd0;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      tx_run_q    <= tx_run_d;
      irq_low_q   <= irq_low_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign tx_run    = tx_run_q;
  assign count     = count_q;
  assign irq_low   = irq_low_q;
  assign underrun  = underrun_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_tx_refill_ctrl.sv
// Bench for pulse_tx_refill_ctrl: directed scenarios then randomized episodes,
// checked each cycle against a phase-level reference model and a write scoreboard.
module tb_pulse_tx_refill_ctrl;

  localparam int DEPTH = 5;

  // phases of the reference model, numbered as the DUT reports them on dbg_state
  localparam int P_IDLE = 0, P_PRIME = 1, P_RUN = 2, P_DRAIN = 3, P_UNDER = 4, P_DONE = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  prime_thresh = 3'd0;
  logic [2:0]  low_water = 3'd0;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ready;
  logic        word_done = 1'b0;
  logic        mem_we;
  logic [2:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        tx_run;
  logic [2:0]  count;
  logic        irq_low;
  logic        irq_clr = 1'b0;
  logic        underrun;
  logic        done;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  pulse_tx_refill_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prime_thresh(prime_thresh),
    .low_water(low_water), .flush(flush), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .word_done(word_done), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .tx_run(tx_run), .count(count), .irq_low(irq_low),
    .irq_clr(irq_clr), .underrun(underrun), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];

  int m_phase = P_IDLE;
  int m_count = 0;
  int m_wp = 0;
  bit m_pend = 0, m_txrun = 0, m_under = 0, m_done = 0, m_irq = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return enable && (m_phase == P_PRIME || m_phase == P_RUN) && (m_count < DEPTH);
  endfunction

  function automatic int eff_thr(input int p);
    if (p == 0) return 1;
    if (p > DEPTH) return DEPTH;
    return p;
  endfunction

  // Reference model: advances one clock using the inputs present at the edge.
  task automatic model_step();
    int hs, dec, nc, np;
    bit wd_active;
    if (!rst_n) begin
      m_phase = P_IDLE; m_count = 0; m_wp = 0; m_pend = 0;
      m_txrun = 0; m_under = 0; m_done = 0; m_irq = 0;
      chk_en = 1;
    end else if (!enable) begin
      m_phase = P_IDLE; m_count = 0; m_wp = 0; m_pend = 0;
      m_txrun = 0; m_under = 0; m_done = 0; m_irq = 0;
    end else begin
      hs = (wr_valid && m_ready()) ? 1 : 0;
      wd_active = word_done && (m_phase == P_RUN || m_phase == P_DRAIN);
      dec = (wd_active && m_count > 0) ? 1 : 0;
      nc = m_count + hs - dec;
      np = m_phase;
      case (m_phase)
        P_IDLE:  np = P_PRIME;
        P_PRIME: if (m_count >= eff_thr(int'(prime_thresh)) && !m_pend) np = P_RUN;
        P_RUN: begin
          if (wd_active && nc == 0) begin
            if (flush) begin np = P_DONE; m_done = 1; end
            else begin np = P_UNDER; m_under = 1; end
          end else if (flush) np = P_DRAIN;
        end
        P_DRAIN: if (wd_active && nc == 0) begin np = P_DONE; m_done = 1; end
        default: np = m_phase;
      endcase
      if (m_phase == P_RUN && m_count <= int'(low_water)) m_irq = 1;
      else if (irq_clr) m_irq = 0;
      if (hs == 1) begin
        exp_q.push_back({m_wp[2:0], wr_data});
        m_wp = (m_wp + 1) % DEPTH;
      end
      m_pend = (hs == 1);
      m_count = nc;
      m_phase = np;
      m_txrun = (np == P_RUN || np == P_DRAIN);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: mid-cycle comparison of every output and the write stream.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("wr_ready", wr_ready, m_ready());
        chk("count", count, m_count);
        chk("tx_run", tx_run, m_txrun);
        chk("underrun", underrun, m_under);
        chk("done", done, m_done);
        chk("irq_low", irq_low, m_irq);
        chk("state", dbg_state, m_phase);
        chk("mem_we", mem_we, m_pend);
        if (mem_we === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("mem_write_unexpected", {mem_waddr, mem_wdata}, 35'h7ffffffff);
          end else begin
            e = exp_q.pop_front();
            chk("mem_write", {mem_waddr, mem_wdata}, e);
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_wd();
    word_done = 1'b1;
    step();
    word_done = 1'b0;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("reset_count", count, 0);
    chk("reset_tx_run", tx_run, 0);

    // prime with threshold 2
    enable = 1'b1; prime_thresh = 3'd2; low_water = 3'd0;
    step();
    push(32'hAAAA_0001);
    push(32'hBBBB_0002);
    step(3);
    chk("prime_count", count, 2);
    chk("prime_tx_run", tx_run, 1);

    // fill the ring, free one slot, next push wraps to address 0
    push(32'h0000_0003);
    push(32'h0000_0004);
    push(32'h0000_0005);
    step();
    chk("full_ready", wr_ready, 0);
    chk("full_count", count, 5);
    pulse_wd();
    chk("free_count", count, 4);
    chk("free_ready", wr_ready, 1);
    push(32'hC0C0_0006);
    chk("wrap_addr", mem_waddr, 0);

    // bring count to 1, then push and consume together
    repeat (4) pulse_wd();
    chk("pre_sim_count", count, 1);
    wr_valid = 1'b1; wr_data = 32'h5151_0007; word_done = 1'b1;
    step();
    wr_valid = 1'b0; word_done = 1'b0;
    chk("sim_count", count, 1);
    chk("sim_underrun", underrun, 0);

    // underrun
    step();
    pulse_wd();
    chk("under_flag", underrun, 1);
    chk("under_tx_run", tx_run, 0);
    wr_valid = 1'b1; wr_data = 32'hDEAD_0008;
    step(3);
    wr_valid = 1'b0;
    enable = 1'b0;
    step(2);
    enable = 1'b1;

    // low-water interrupt, clear, then drain to done
    prime_thresh = 3'd2; low_water = 3'd1;
    step();
    push(32'h1111_0009);
    push(32'h2222_000A);
    step(3);
    pulse_wd();
    step();
    chk("irq_set", irq_low, 1);
    push(32'h3333_000B);
    push(32'h4444_000C);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_cleared", irq_low, 0);
    flush = 1'b1;
    step();
    pulse_wd(); step();
    pulse_wd(); step();
    pulse_wd();
    chk("drain_done", done, 1);
    chk("drain_tx_run", tx_run, 0);
    flush = 1'b0;
    enable = 1'b0;
    step();

    // reset the cycle after a handshake
    enable = 1'b1; prime_thresh = 3'd1;
    step();
    push(32'h7777_000D);
    rst_n = 1'b0;
    step();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_count", count, 0);
    chk("rst_state", dbg_state, P_IDLE);
    rst_n = 1'b1;
    step();

    // randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
      enable = 1'b0;
      step();
      prime_thresh = 3'($urandom_range(0, 7));
      low_water = 3'($urandom_range(0, 7));
      enable = 1'b1;
      for (int c = 0; c < 60; c++) begin
        wr_valid  = ($urandom_range(0, 99) < 50);
        wr_data   = $urandom;
        word_done = ($urandom_range(0, 99) < 35);
        irq_clr   = ($urandom_range(0, 99) < 10);
        if (c > 35 && $urandom_range(0, 99) < 15) flush = 1'b1;
        rst_n     = ($urandom_range(0, 199) != 0);
        step();
      end
      wr_valid = 1'b0; word_done = 1'b0; irq_clr = 1'b0; flush = 1'b0; rst_n = 1'b1;
    end

    step(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
